// File: rtl/mic_adc_reader.sv
// SPI master for an ADCS7476-style microphone ADC: paced 16-bit frames, 12-bit sample
// output with a valid pulse, a square sample strobe, and bad-frame accounting.
module mic_adc_reader #(
  parameter int SCLK_HALF     = 4,
  parameter int SAMPLE_PERIOD = 5000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_mic_miso,
  output logic        o_mic_cs_n,
  output logic        o_mic_sclk,
  output logic [11:0] o_sample,
  output logic        o_sample_valid,
  output logic        o_sample_clk,
  output logic        o_frame_err,
  output logic [7:0]  o_err_count
);

  // state | meaning
  // IDLE  | CS high, waiting for period wrap with en
  // START | CS low, SCLK high for one half period
  // SHIFT | SCLK toggling, MISO captured on each rising edge
  // STOP  | last half period, then CS high and frame evaluation
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int PER_W  = $clog2(SAMPLE_PERIOD);
  localparam int HALF_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int SCK_W  = (SAMPLE_PERIOD / 2 > 1) ? $clog2(SAMPLE_PERIOD / 2) : 1;

  localparam logic [PER_W-1:0]  PER_MAX  = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [HALF_W-1:0] HALF_LD  = HALF_W'(SCLK_HALF - 1);
  localparam logic [SCK_W-1:0]  SCK_LD   = SCK_W'(SAMPLE_PERIOD / 2 - 1);

  generate
    if (SCLK_HALF < 1 || SAMPLE_PERIOD < 35 * SCLK_HALF) begin : g_bad_cfg
      $error("mic_adc_reader: SAMPLE_PERIOD must be >= 35*SCLK_HALF and SCLK_HALF >= 1");
    end
  endgenerate

  logic [PER_W-1:0]  r_period;
  logic [1:0]        r_state;
  logic [HALF_W-1:0] r_tmr;
  logic [3:0]        r_nrise;
  logic [15:0]       r_shift;
  logic              r_cs_n;
  logic              r_sclk;
  logic [11:0]       r_sample;
  logic              r_valid;
  logic              r_ferr;
  logic [7:0]        r_err_count;
  logic              r_sck;
  logic [SCK_W-1:0]  r_sck_tmr;

  logic w_tc;
  logic w_good;

  assign w_tc   = (r_tmr == '0);
  assign w_good = (r_shift[15:12] == 4'd0);

  // Free-running frame pacing, independent of en
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_period <= '0;
    end else if (r_period == PER_MAX) begin
      r_period <= '0;
    end else begin
      r_period <= r_period + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_tmr       <= '0;
      r_nrise     <= '0;
      r_shift     <= '0;
      r_cs_n      <= 1'b1;
      r_sclk      <= 1'b1;
      r_sample    <= '0;
      r_valid     <= 1'b0;
      r_ferr      <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_period == '0 && i_en) begin
            r_state <= ST_START;
            r_cs_n  <= 1'b0;
            r_tmr   <= HALF_LD;
            r_nrise <= '0;
          end
        end
        ST_START: begin
          if (w_tc) begin
            r_state <= ST_SHIFT;
            r_sclk  <= 1'b0;
            r_tmr   <= HALF_LD;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        ST_SHIFT: begin
          if (w_tc) begin
            r_tmr  <= HALF_LD;
            r_sclk <= ~r_sclk;
            // sclk currently low means this edge raises it: capture MISO
            if (!r_sclk) begin
              r_shift <= {r_shift[14:0], i_mic_miso};
              r_nrise <= r_nrise + 1'b1;
              if (r_nrise == 4'd15) begin
                r_state <= ST_STOP;
              end
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        ST_STOP: begin
          if (w_tc) begin
            r_state <= ST_IDLE;
            r_cs_n  <= 1'b1;
            if (w_good) begin
              r_sample <= r_shift[11:0];
              r_valid  <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
              if (r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
              end
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cs_n  <= 1'b1;
          r_sclk  <= 1'b1;
        end
      endcase
    end
  end

  // Strobe rises one clk after the sample lands, high for half a sample period
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sck     <= 1'b0;
      r_sck_tmr <= '0;
    end else if (r_valid) begin
      r_sck     <= 1'b1;
      r_sck_tmr <= SCK_LD;
    end else if (r_sck) begin
      if (r_sck_tmr == '0) begin
        r_sck <= 1'b0;
      end else begin
        r_sck_tmr <= r_sck_tmr - 1'b1;
      end
    end
  end

  assign o_mic_cs_n     = r_cs_n;
  assign o_mic_sclk     = r_sclk;
  assign o_sample       = r_sample;
  assign o_sample_valid = r_valid;
  assign o_sample_clk   = r_sck;
  assign o_frame_err    = r_ferr;
  assign o_err_count    = r_err_count;

endmodule

// File: doc/mic_adc_reader.md
Name: mic_adc_reader

Overview:
- SPI master for the microphone ADC (ADCS7476-style, 16-bit frame: 4 leading zeros then 12-bit sample, MSB first).
- Produces the 12-bit sample word and a per-sample rising-edge strobe that downstream sample consumers (volume indicator, FFT front end) clock on.
- Paces conversions at a fixed sample rate derived from the 100 MHz system clock.

Parameters:
- SCLK_HALF, 4, system clocks per SCLK half-period (12.5 MHz SCLK at 100 MHz).
- SAMPLE_PERIOD, 5000, system clocks between frame starts (20 kHz). Must be >= 35*SCLK_HALF; elaboration fails otherwise.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start new frames while high
- mic_miso  in  1  ADC serial data
- mic_cs_n  out  1  ADC chip select, active low
- mic_sclk  out  1  ADC serial clock, idles high
- sample  out  12  last good sample
- sample_valid  out  1  one-clk pulse when sample updates
- sample_clk  out  1  square strobe; rising edge one clk after sample updates
- frame_err  out  1  one-clk pulse on bad leading bits
- err_count  out  8  saturating count of bad frames

Behaviour:
- Reset (async assert, sync release):
  - mic_cs_n=1, mic_sclk=1, sample=0, sample_valid=0, sample_clk=0, frame_err=0, err_count=0.
  - State IDLE, period counter=0, shift register=0.
- Period counter: free-running 0..SAMPLE_PERIOD-1, wraps to 0. Runs regardless of en.
- States:
  - IDLE: if counter==0 and en=1 -> START. mic_cs_n drops on that same clk edge.
  - START: hold SCLK_HALF clks with sclk high -> SHIFT.
  - SHIFT: sclk toggles every SCLK_HALF clks, beginning with a fall. On each clk edge that drives sclk high, shift mic_miso into bit 0 of a 16-bit register. After the 16th rising edge -> STOP.
  - STOP: hold SCLK_HALF clks, then on one edge: mic_cs_n=1 and the frame is evaluated -> IDLE.
- Frame timing: CS low at T. SCLK edges at T+k*SCLK_HALF, k=1..32 (odd k falling, even k rising). CS high at T+33*SCLK_HALF.
- Frame evaluation, on the CS-high edge:
  - Good frame (shift[15:12]==0): sample<=shift[11:0] and sample_valid=1 for that single clk.
  - Bad frame: sample unchanged, no sample_valid, frame_err=1 for one clk, err_count increments and saturates at 255.
- sample_clk:
  - Goes high the clk after sample_valid and stays high SAMPLE_PERIOD/2 clks, then low.
  - Not raised on bad frames.
  - sample is stable around every sample_clk rising edge.
- en: sampled only in IDLE at counter==0. Deasserting en mid-frame completes that frame normally.
- Reset mid-frame: CS and SCLK return high immediately and the frame is discarded. After release, the next frame starts at counter 0.
- No back-to-back overlap: SAMPLE_PERIOD constraint guarantees IDLE at every counter wrap.

Test Plan:
- Reset then en=1, ADC model returns 0x0ABC -> CS low at clk 0, 16 SCLK rises spaced 8 clks, CS high at clk 132, sample=0xABC with one-clk sample_valid at clk 132, sample_clk rises at clk 133 and stays high 2500 clks.
- Continuous en=1, model returns ramp 0x000,0x001,… -> frames start every 5000 clks, sample increments by 1 each frame, exactly one sample_valid per 5000 clks.
- Model returns 0xF123 -> frame_err pulses once, err_count=1, sample keeps previous value, no sample_clk rise. After 300 bad frames err_count=255.
- en dropped at clk 60 of a frame -> that frame completes with a valid sample, no further CS activity, mic_sclk stays 1.
- rst_n asserted at clk 70 mid-frame -> mic_cs_n and mic_sclk high within the same cycle, sample=0. After release, the first frame starts at counter wrap and captures correctly.
- Model returns 0x0FFF and 0x0000 -> sample=0xFFF then 0x000. MSB-first ordering is verified by a 0x0800 pattern yielding sample=0x800.
